// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch, buffer and decode stages.
package fetch_pkg;

  localparam int PC_W = 16;
  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ibuf_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fd_state_t;

endpackage

// File: rtl/ibuf_mem.sv
// Entry storage for the fetch/decode buffer: one write port, one async read port.
module ibuf_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        we,
  input  logic [AW-1:0] waddr,
  input  ibuf_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output ibuf_entry_t rdata
);

  ibuf_entry_t mem_q [DEPTH];

  // Data carries no reset; occupancy in the parent decides what is valid.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// In-order instruction queue between fetch and decode with branch flush and HALT drain.
module fetch_decode_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fd_state_t     state_q, state_d;
  logic          push, pop, mem_we;
  ibuf_entry_t   wr_entry, rd_entry;

  always_comb begin
    in_ready  = ~reset & (state_q == RUN) & (count_q != CW'(DEPTH));
    out_valid = (count_q != '0) & (state_q != HALTED);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    halted    = (state_q == HALTED);
    count     = count_q;
    out_pc    = (count_q != '0) ? rd_entry.pc : '0;
    out_instr = (count_q != '0) ? rd_entry.instr : '0;
    mem_we    = push & ~flush;
    wr_entry  = '{pc: in_pc, instr: in_instr};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    // A flush wins over any same-cycle push/pop; a halted front end ignores it.
    if (flush && state_q != HALTED) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = RUN;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      case (state_q)
        RUN:     if (push && in_instr == HALT_INSTR) state_d = DRAIN;
        // No pushes in DRAIN, so the last entry popped is the HALT itself.
        DRAIN:   if (pop && count_q == CW'(1)) state_d = HALTED;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  ibuf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

endmodule
